// File: rtl/uart_tx.sv
// UART serial transmitter.
// Sends LSB-first frames built from a start bit, DBIT data bits, an optional
// parity bit and a stop period of SB_TICK ticks. One bit lasts 16 rising
// edges of the 16x oversampling tick s_tick. s_tick is only used as an
// enable, so every register here is clocked by clk.
module uart_tx #(
   parameter int DBIT    = 8,   // data bits per frame, 5..8
   parameter int SB_TICK = 16,  // stop length in ticks: 16, 24 or 32
   parameter int PARITY  = 0    // 0 = none, 1 = even, 2 = odd
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] din,
   output logic            tx_busy,
   output logic            tx_done_tick,
   output logic            tx
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   // Last tick index of one bit period, last data bit index and last stop tick.
   localparam logic [4:0] BIT_LAST  = 5'd15;
   localparam logic [2:0] DATA_LAST = 3'(DBIT - 1);
   localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
   localparam logic       HAS_PAR   = (PARITY != 0);
   localparam logic       ODD_PAR   = (PARITY == 2);

   state_t          state;
   logic [4:0]      s_cnt;
   logic [2:0]      n_cnt;
   logic [DBIT-1:0] b;
   logic            par_acc;
   logic            s_tick_d;
   logic            tick_en;
   logic            par_next;

   // A tick is a rising edge of s_tick, so a toggling ticker held high counts once.
   assign tick_en = s_tick & ~s_tick_d;

   // Parity including the data bit that is finishing right now.
   assign par_next = par_acc ^ b[0];

   // Delay s_tick by one clk for rising-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_tick_d <= 1'b0;
      end else begin
         s_tick_d <= s_tick;
      end
   end

   // Frame sequencer; tx, tx_busy and tx_done_tick are set on each transition
   // so the serial line is driven straight from a flop and never glitches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         s_cnt        <= 5'd0;
         n_cnt        <= 3'd0;
         b            <= '0;
         par_acc      <= 1'b0;
         tx           <= 1'b1;
         tx_busy      <= 1'b0;
         tx_done_tick <= 1'b0;
      end else begin
         tx_done_tick <= 1'b0;
         case (state)
            IDLE: begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               // The cycle in which tx_done_tick is high still counts as busy,
               // so a request seen then waits for the following clk.
               if (tx_start && !tx_done_tick) begin
                  b       <= din;
                  s_cnt   <= 5'd0;
                  n_cnt   <= 3'd0;
                  par_acc <= 1'b0;
                  tx      <= 1'b0;
                  tx_busy <= 1'b1;
                  state   <= START;
               end
            end

            START: begin
               if (tick_en) begin
                  if (s_cnt == BIT_LAST) begin
                     s_cnt <= 5'd0;
                     n_cnt <= 3'd0;
                     tx    <= b[0];
                     state <= DATA;
                  end else begin
                     s_cnt <= s_cnt + 5'd1;
                  end
               end
            end

            DATA: begin
               if (tick_en) begin
                  if (s_cnt == BIT_LAST) begin
                     s_cnt   <= 5'd0;
                     b       <= b >> 1;
                     par_acc <= par_next;
                     if (n_cnt == DATA_LAST) begin
                        if (HAS_PAR) begin
                           tx    <= par_next ^ ODD_PAR;
                           state <= PAR;
                        end else begin
                           tx    <= 1'b1;
                           state <= STOP;
                        end
                     end else begin
                        n_cnt <= n_cnt + 3'd1;
                        tx    <= b[1];
                     end
                  end else begin
                     s_cnt <= s_cnt + 5'd1;
                  end
               end
            end

            PAR: begin
               if (tick_en) begin
                  if (s_cnt == BIT_LAST) begin
                     s_cnt <= 5'd0;
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     s_cnt <= s_cnt + 5'd1;
                  end
               end
            end

            STOP: begin
               tx <= 1'b1;
               if (tick_en) begin
                  if (s_cnt == STOP_LAST) begin
                     s_cnt        <= 5'd0;
                     tx_done_tick <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     s_cnt <= s_cnt + 5'd1;
                  end
               end
            end

            default: begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               s_cnt   <= 5'd0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx.
// Four transmitters with different frame formats share one stimulus. A
// tick-counting reference model predicts tx, tx_busy and tx_done_tick for
// each of them every clk from the frame layout alone.
module tb_uart_tx;

   localparam int N = 4;
   localparam int DBIT_C [N] = '{8, 8, 8, 5};
   localparam int SB_C   [N] = '{16, 24, 32, 16};
   localparam int PAR_C  [N] = '{0, 1, 2, 1};

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       s_tick   = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] din      = 8'h00;

   logic tx_w   [N];
   logic busy_w [N];
   logic done_w [N];

   int checks = 0;
   int errors = 0;

   string tx_tag   [N] = '{"tx_a", "tx_b", "tx_c", "tx_d"};
   string busy_tag [N] = '{"busy_a", "busy_b", "busy_c", "busy_d"};
   string done_tag [N] = '{"done_a", "done_b", "done_c", "done_d"};
   string cnt_tag  [N] = '{"frames_a", "frames_b", "frames_c", "frames_d"};

   // Ticker control: 0 = off, 1 = one-clk pulse every tick_period, 2 = toggle.
   int tick_mode   = 0;
   int tick_period = 4;
   int tick_half   = 55;
   int tick_cnt    = 0;

   bit chk_en = 1'b0;

   // Reference model state.
   bit          m_active   [N];
   int          m_t        [N];
   logic [15:0] m_bits     [N];
   logic        exp_tx     [N];
   logic        exp_busy   [N];
   logic        exp_done   [N];
   int          m_done_cnt [N];
   int          dut_done_cnt [N];
   logic        m_prev_s;

   always #5 clk = ~clk;

   uart_tx #(.DBIT(DBIT_C[0]), .SB_TICK(SB_C[0]), .PARITY(PAR_C[0])) dut_a (
      .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start),
      .din(din), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .tx(tx_w[0]));

   uart_tx #(.DBIT(DBIT_C[1]), .SB_TICK(SB_C[1]), .PARITY(PAR_C[1])) dut_b (
      .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start),
      .din(din), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .tx(tx_w[1]));

   uart_tx #(.DBIT(DBIT_C[2]), .SB_TICK(SB_C[2]), .PARITY(PAR_C[2])) dut_c (
      .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start),
      .din(din), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]), .tx(tx_w[2]));

   uart_tx #(.DBIT(DBIT_C[3]), .SB_TICK(SB_C[3]), .PARITY(PAR_C[3])) dut_d (
      .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start),
      .din(din[4:0]), .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]), .tx(tx_w[3]));

   // Single comparison point: counts every check and reports each mismatch.
   task automatic check_output(input string tag, input logic [31:0] obs,
                               input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, expv);
      end
   endtask

   // Line levels of one frame, one entry per bit period, start bit first.
   function automatic logic [15:0] frame_bits(input int k, input logic [7:0] d);
      logic [15:0] f;
      logic        p;
      f = 16'hFFFF;
      p = 1'b0;
      f[0] = 1'b0;
      for (int i = 0; i < DBIT_C[k]; i++) begin
         f[1 + i] = d[i];
         p = p ^ d[i];
      end
      if (PAR_C[k] != 0) f[1 + DBIT_C[k]] = (PAR_C[k] == 1) ? p : ~p;
      return f;
   endfunction

   function automatic int frame_nbits(input int k);
      return 1 + DBIT_C[k] + ((PAR_C[k] != 0) ? 1 : 0);
   endfunction

   function automatic int frame_len(input int k);
      return frame_nbits(k) * 16 + SB_C[k];
   endfunction

   // Ticker driven on the falling edge, away from the sampling edge.
   always @(negedge clk) begin
      case (tick_mode)
         1: begin
            tick_cnt++;
            if (tick_cnt >= tick_period) begin
               tick_cnt = 0;
               s_tick   = 1'b1;
            end else begin
               s_tick = 1'b0;
            end
         end
         2: begin
            tick_cnt++;
            if (tick_cnt >= tick_half) begin
               tick_cnt = 0;
               s_tick   = ~s_tick;
            end
         end
         default: begin
            tick_cnt = 0;
            s_tick   = 1'b0;
         end
      endcase
   end

   // Reference model: counts ticks since acceptance and looks up the line level.
   always @(posedge clk or negedge reset) begin
      logic tick;
      if (!reset) begin
         m_prev_s = 1'b0;
         for (int k = 0; k < N; k++) begin
            m_active[k] = 1'b0;
            m_t[k]      = 0;
            exp_tx[k]   = 1'b1;
            exp_busy[k] = 1'b0;
            exp_done[k] = 1'b0;
         end
      end else begin
         tick     = s_tick && !m_prev_s;
         m_prev_s = s_tick;
         for (int k = 0; k < N; k++) begin
            if (!m_active[k]) begin
               if (tx_start && !exp_done[k]) begin
                  m_active[k] = 1'b1;
                  m_t[k]      = 0;
                  m_bits[k]   = frame_bits(k, din);
                  exp_tx[k]   = 1'b0;
                  exp_busy[k] = 1'b1;
               end else begin
                  exp_tx[k]   = 1'b1;
                  exp_busy[k] = 1'b0;
               end
               exp_done[k] = 1'b0;
            end else begin
               exp_done[k] = 1'b0;
               exp_busy[k] = 1'b1;
               if (tick) m_t[k]++;
               if (m_t[k] == frame_len(k)) begin
                  m_active[k] = 1'b0;
                  exp_done[k] = 1'b1;
                  exp_tx[k]   = 1'b1;
                  m_done_cnt[k]++;
               end else if (m_t[k] / 16 < frame_nbits(k)) begin
                  exp_tx[k] = m_bits[k][m_t[k] / 16];
               end else begin
                  exp_tx[k] = 1'b1;
               end
            end
         end
      end
   end

   // Compare every transmitter against the model once per clk.
   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (done_w[k]) dut_done_cnt[k]++;
         if (chk_en) begin
            check_output(tx_tag[k],   32'(tx_w[k]),   32'(exp_tx[k]));
            check_output(busy_tag[k], 32'(busy_w[k]), 32'(exp_busy[k]));
            check_output(done_tag[k], 32'(done_w[k]), 32'(exp_done[k]));
         end
      end
   end

   // Present din with tx_start held for the given number of clks.
   task automatic apply_stimulus(input logic [7:0] d, input int hold);
      @(negedge clk);
      din      = d;
      tx_start = 1'b1;
      repeat (hold) @(negedge clk);
      tx_start = 1'b0;
   endtask

   function automatic bit any_busy();
      bit b;
      b = 1'b0;
      for (int k = 0; k < N; k++) b = b | m_active[k] | busy_w[k] | exp_busy[k];
      return b;
   endfunction

   // Wait for every transmitter to go idle, then compare frame counts.
   task automatic wait_idle(input int budget);
      int n;
      bit ok;
      n = 0;
      while (any_busy() && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = (n < budget);
      check_output("idle_wait", 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      for (int k = 0; k < N; k++)
         check_output(cnt_tag[k], 32'(dut_done_cnt[k]), 32'(m_done_cnt[k]));
   endtask

   initial begin
      int n;
      #2 reset = 1'b0;
      tick_mode   = 1;
      tick_period = 4;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      for (int k = 0; k < N; k++) begin
         check_output("rst_tx",   32'(tx_w[k]),   32'd1);
         check_output("rst_busy", 32'(busy_w[k]), 32'd0);
         check_output("rst_done", 32'(done_w[k]), 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      // Alternating pattern, then the parity example pattern.
      apply_stimulus(8'h55, 1);
      wait_idle(5000);
      apply_stimulus(8'hA5, 1);
      wait_idle(5000);

      // tx_start held across frames with din changing mid-frame.
      @(negedge clk);
      din      = 8'h3C;
      tx_start = 1'b1;
      repeat (300) @(negedge clk);
      din = 8'hC3;
      repeat (700) @(negedge clk);
      din = 8'h81;
      repeat (200) @(negedge clk);
      tx_start = 1'b0;
      wait_idle(5000);

      // Reset in the middle of a frame, then a clean frame afterwards.
      apply_stimulus(8'h96, 1);
      n = 0;
      while (m_t[0] < 70 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_output("mid_wait", 32'(m_t[0]), 32'd70);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      for (int k = 0; k < N; k++) begin
         check_output("abort_tx",   32'(tx_w[k]),   32'd1);
         check_output("abort_busy", 32'(busy_w[k]), 32'd0);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      apply_stimulus(8'h0F, 1);
      wait_idle(5000);

      // Randomized data, tick spacing, request length and idle gaps.
      for (int r = 0; r < 8; r++) begin
         tick_period = int'($urandom_range(2, 6));
         apply_stimulus(8'($urandom), int'($urandom_range(1, 3)));
         wait_idle(8000);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      // Toggling ticker: 55 clk high, 55 clk low.
      tick_mode = 2;
      tick_half = 55;
      apply_stimulus(8'h5A, 1);
      wait_idle(25000);

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
      $finish;
   end

endmodule
